// File: rtl/wb_nor_arbiter.sv
// wb_nor_arbiter: two-master pipelined Wishbone arbiter for nor_bus with
// outstanding-request tracking, clean-boundary handover and hung-transfer abort.
module wb_nor_arbiter #(
    parameter int ADDRBITS       = 26,
    parameter int DATABITS       = 16,
    parameter int OUTST_BITS     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FIXED_PRIO     = 0
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [ADDRBITS-1:0] m0_adr_i,
    input  logic [DATABITS-1:0] m0_dat_i,
    output logic [DATABITS-1:0] m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    output logic                m0_stall_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [ADDRBITS-1:0] m1_adr_i,
    input  logic [DATABITS-1:0] m1_dat_i,
    output logic [DATABITS-1:0] m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic                m1_stall_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [ADDRBITS-1:0] s_adr_o,
    output logic [DATABITS-1:0] s_dat_o,
    input  logic [DATABITS-1:0] s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    input  logic                s_stall_i,
    output logic [1:0]          owner_o,
    output logic                timeout_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    state_t                state_q, state_d;
    logic [1:0]            owner_q, owner_d;
    logic [OUTST_BITS-1:0] outst_q, outst_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  rr_q, rr_d;
    logic sel0, sel1, o_cyc, o_stb, full, resp, inc, dec, fire, req0, req1;

    always_comb begin
        sel0       = (state_q == BUSY) && (owner_q == 2'b01);
        sel1       = (state_q == BUSY) && (owner_q == 2'b10);
        o_cyc      = (sel0 & m0_cyc_i) | (sel1 & m1_cyc_i);
        o_stb      = (sel0 & m0_stb_i) | (sel1 & m1_stb_i);
        full       = &outst_q;
        resp       = s_ack_i | s_err_i;
        // cyc is held while responses are still owed, even after the owner leaves
        s_cyc_o    = o_cyc | ((state_q == BUSY) && (outst_q != '0));
        s_stb_o    = o_cyc & o_stb & ~full;
        s_we_o     = (sel0 & m0_we_i) | (sel1 & m1_we_i);
        s_adr_o    = sel0 ? m0_adr_i : sel1 ? m1_adr_i : '0;
        s_dat_o    = sel0 ? m0_dat_i : sel1 ? m1_dat_i : '0;
        inc        = s_stb_o & ~s_stall_i;
        dec        = resp & (outst_q != '0);
        fire       = (state_q == BUSY) && (outst_q != '0) && !resp && (tmo_q == TMAX);
        m0_dat_o   = sel0 ? s_dat_i : '0;
        m0_ack_o   = sel0 & m0_cyc_i & s_ack_i;
        m0_err_o   = sel0 & m0_cyc_i & (s_err_i | fire);
        m0_stall_o = ~sel0 | s_stall_i | full;
        m1_dat_o   = sel1 ? s_dat_i : '0;
        m1_ack_o   = sel1 & m1_cyc_i & s_ack_i;
        m1_err_o   = sel1 & m1_cyc_i & (s_err_i | fire);
        m1_stall_o = ~sel1 | s_stall_i | full;
        owner_o    = owner_q;
        timeout_o  = fire;
        req0       = m0_cyc_i & m0_stb_i;
        req1       = m1_cyc_i & m1_stb_i;
        outst_d    = outst_q + OUTST_BITS'(inc) - OUTST_BITS'(dec);
        tmo_d      = ((state_q == BUSY) && (outst_q != '0) && !resp) ? tmo_q + 1'b1 : '0;
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        if (state_q == IDLE) begin
            if (req0 | req1) begin
                state_d = BUSY;
                owner_d = (req1 & (~req0 | ((FIXED_PRIO == 0) & rr_q))) ? 2'b10 : 2'b01;
                if (req0 & req1 & (FIXED_PRIO == 0))
                    rr_d = ~rr_q;
            end
        end else if (state_q == ABORT) begin
            state_d = IDLE;
            owner_d = 2'b00;
            outst_d = '0;
        end else if (fire) begin
            state_d = ABORT;
        end else if (!o_cyc && (outst_d == '0)) begin
            state_d = IDLE;
            owner_d = 2'b00;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            owner_q <= 2'b00;
            outst_q <= '0;
            tmo_q   <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            outst_q <= outst_d;
            tmo_q   <= tmo_d;
            rr_q    <= rr_d;
        end
    end
endmodule

// File: tb/tb_wb_nor_arbiter.sv
// tb_wb_nor_arbiter: directed bench for wb_nor_arbiter with a cycle-level
// transaction model compared on every falling edge.
module tb_wb_nor_arbiter;
    localparam int AW = 26;
    localparam int DW = 16;
    localparam int OB = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
    logic [AW-1:0] m0_adr_i = '0;
    logic [DW-1:0] m0_dat_i = '0;
    logic m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
    logic [AW-1:0] m1_adr_i = '0;
    logic [DW-1:0] m1_dat_i = '0;
    logic [DW-1:0] s_dat_i = '0;
    logic s_ack_i = 0, s_err_i = 0, s_stall_i = 0;
    logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic m0_ack_o, m0_err_o, m0_stall_o, m1_ack_o, m1_err_o, m1_stall_o;
    logic s_cyc_o, s_stb_o, s_we_o, timeout_o;
    logic [AW-1:0] s_adr_o;
    logic [1:0] owner_o;

    int checks = 0;
    int errors = 0;

    wb_nor_arbiter #(.ADDRBITS(AW), .DATABITS(DW), .OUTST_BITS(OB),
                     .TIMEOUT_CYCLES(TO), .FIXED_PRIO(0)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i),
        .owner_o(owner_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    // Model: owner 0 none / 1 m0 / 2 m1, abort_m marks the abort cycle,
    // pend counts owed responses, quiet counts response-free cycles.
    int owner = 0;
    bit abort_m = 0;
    int pend = 0;
    int quiet = 0;
    int ptr = 0;
    int npend;
    bit f, c, r;

    logic active, mc, ms, mwe, full, resp, e_stb, fire;
    logic [AW-1:0] madr;
    logic [DW-1:0] mdat;
    assign active = owner != 0 && !abort_m;
    assign mc     = active && (owner == 1 ? m0_cyc_i : m1_cyc_i);
    assign ms     = owner == 1 ? m0_stb_i : m1_stb_i;
    assign mwe    = active && (owner == 1 ? m0_we_i : m1_we_i);
    assign madr   = !active ? '0 : owner == 1 ? m0_adr_i : m1_adr_i;
    assign mdat   = !active ? '0 : owner == 1 ? m0_dat_i : m1_dat_i;
    assign full   = pend == (1 << OB) - 1;
    assign resp   = s_ack_i | s_err_i;
    assign e_stb  = mc && ms && !full;
    assign fire   = active && pend > 0 && quiet == TO - 1 && !resp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner = 0; abort_m = 0; pend = 0; quiet = 0; ptr = 0;
        end else begin
            f = fire; c = mc; r = resp;
            npend = pend + int'(e_stb && !s_stall_i) - int'(r && pend > 0);
            if (owner == 0) begin
                if (m0_cyc_i && m0_stb_i && m1_cyc_i && m1_stb_i) begin
                    owner = ptr + 1;
                    ptr = 1 - ptr;
                end else if (m0_cyc_i && m0_stb_i) owner = 1;
                else if (m1_cyc_i && m1_stb_i) owner = 2;
            end else if (abort_m) begin
                owner = 0; abort_m = 0; pend = 0; quiet = 0;
            end else begin
                if (f) begin
                    abort_m = 1;
                    quiet = 0;
                end else begin
                    quiet = (r || pend == 0) ? 0 : quiet + 1;
                    if (!c && npend == 0) owner = 0;
                end
                pend = npend;
            end
        end
    end

    logic [85:0] got_v, exp_v;
    logic o0, o1;
    always @(negedge clk) begin
        o0 = active && owner == 1;
        o1 = active && owner == 2;
        exp_v = {active && (mc || pend > 0), e_stb, mwe, madr, mdat,
                 o0 ? s_dat_i : 16'h0, o0 && mc && s_ack_i, o0 && mc && (s_err_i || fire), !o0 || s_stall_i || full,
                 o1 ? s_dat_i : 16'h0, o1 && mc && s_ack_i, o1 && mc && (s_err_i || fire), !o1 || s_stall_i || full,
                 owner == 1 ? 2'b01 : owner == 2 ? 2'b10 : 2'b00, fire};
        got_v = {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
                 m0_dat_o, m0_ack_o, m0_err_o, m0_stall_o,
                 m1_dat_o, m1_ack_o, m1_err_o, m1_stall_o, owner_o, timeout_o};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_compare t=%0t got %h expected %h", $time, got_v, exp_v);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic round(input int who);
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        tick(); #1;
        chk("rr_grant", 32'(owner_o), who == 1 ? 32'h1 : 32'h2);
        tick();
        if (who == 1) m0_stb_i = 0; else m1_stb_i = 0;
        s_ack_i = 1;
        #1;
        chk("rr_ack", 32'(who == 1 ? m0_ack_o : m1_ack_o), 32'h1);
        chk("rr_other_stall", 32'(who == 1 ? m1_stall_o : m0_stall_o), 32'h1);
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        #1;
        chk("rst_s_cyc", 32'(s_cyc_o), 0);
        chk("rst_owner", 32'(owner_o), 0);
        chk("rst_m0_stall", 32'(m0_stall_o), 1);
        chk("rst_m1_stall", 32'(m1_stall_o), 1);
        chk("rst_timeout", 32'(timeout_o), 0);
        rst_n = 1;
        tick();
        // single read by m0
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 26'h0001234;
        tick(); #1;
        chk("t1_grant", 32'(owner_o), 1);
        chk("t1_adr", 32'(s_adr_o), 32'h0001234);
        chk("t1_stb", 32'(s_stb_o), 1);
        tick(); m0_stb_i = 0;
        tick();
        tick(); s_ack_i = 1; s_dat_i = 16'hBEEF; #1;
        chk("t1_ack", 32'(m0_ack_o), 1);
        chk("t1_dat", 32'(m0_dat_o), 32'hBEEF);
        tick(); s_ack_i = 0; s_dat_i = 0; m0_cyc_i = 0;
        tick(); #1;
        chk("t1_release", 32'(owner_o), 0);
        // simultaneous requests from reset pointer
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        tick(); #1;
        chk("t2_first_m0", 32'(owner_o), 1);
        chk("t2_m1_stall", 32'(m1_stall_o), 1);
        tick(); m0_stb_i = 0;
        tick(); s_ack_i = 1; #1;
        chk("t2_m1_still_stall", 32'(m1_stall_o), 1);
        tick(); s_ack_i = 0; m0_cyc_i = 0;
        tick(); #1;
        chk("t2_idle", 32'(owner_o), 0);
        tick(); #1;
        chk("t2_m1_grant", 32'(owner_o), 2);
        tick(); m1_stb_i = 0; s_ack_i = 1;
        tick(); s_ack_i = 0; m1_cyc_i = 0;
        tick();
        round(2);
        round(1);
        round(2);
        // five pipelined reads, at most three outstanding
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 26'h0000100;
        tick();
        tick();
        tick();
        tick(); s_ack_i = 1; s_dat_i = 16'h0A01; #1;
        chk("t3_full_stall", 32'(m0_stall_o), 1);
        chk("t3_full_nostb", 32'(s_stb_o), 0);
        chk("t3_ack1", 32'({m0_ack_o, m0_dat_o}), 32'h10A01);
        for (int i = 1; i <= 4; i++) begin
            tick();
            s_dat_i = 16'h0A01 + 16'(i);
            if (i == 3) m0_stb_i = 0;
            #1;
            chk("t3_ack", 32'({m0_ack_o, m0_dat_o}), 32'h10A01 + 32'(i));
            if (i <= 2) chk("t3_accept", 32'(m0_stall_o), 0);
        end
        tick(); s_ack_i = 0; s_dat_i = 0; m0_cyc_i = 0;
        tick(); #1;
        chk("t3_release", 32'(owner_o), 0);
        // hung read aborts after TO cycles
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        tick(); m0_stb_i = 0;
        repeat (14) tick();
        #1;
        chk("t4_no_early_timeout", 32'(timeout_o), 0);
        tick(); #1;
        chk("t4_err", 32'(m0_err_o), 1);
        chk("t4_timeout", 32'(timeout_o), 1);
        tick(); #1;
        chk("t4_abort_cyc", 32'(s_cyc_o), 0);
        chk("t4_abort_stall", 32'(m0_stall_o), 1);
        m0_cyc_i = 0;
        tick(); #1;
        chk("t4_idle", 32'(owner_o), 0);
        // ack on the would-be timeout cycle wins
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        tick(); m0_stb_i = 0;
        repeat (15) tick();
        s_ack_i = 1; #1;
        chk("t4b_no_timeout", 32'(timeout_o), 0);
        chk("t4b_ack", 32'({m0_ack_o, m0_err_o}), 32'h2);
        tick(); s_ack_i = 0; m0_cyc_i = 0;
        tick(); #1;
        chk("t4b_idle", 32'(owner_o), 0);
        // m1 leaves with two outstanding while m0 waits
        m1_cyc_i = 1; m1_stb_i = 1;
        tick(); #1;
        chk("t5_m1_grant", 32'(owner_o), 2);
        tick();
        tick(); m1_cyc_i = 0; m1_stb_i = 0; m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1; #1;
        chk("t5_cyc_held", 32'(s_cyc_o), 1);
        chk("t5_no_fwd", 32'(m1_ack_o), 0);
        chk("t5_m0_stall", 32'(m0_stall_o), 1);
        tick(); #1;
        chk("t5_cyc_held2", 32'(s_cyc_o), 1);
        chk("t5_no_fwd2", 32'(m1_ack_o), 0);
        tick(); s_ack_i = 0; #1;
        chk("t5_idle", 32'(owner_o), 0);
        chk("t5_cyc_low", 32'(s_cyc_o), 0);
        tick(); #1;
        chk("t5_m0_grant", 32'(owner_o), 1);
        tick(); m0_stb_i = 0; s_ack_i = 1;
        tick(); s_ack_i = 0; m0_cyc_i = 0;
        tick();
        // reset in the middle of a write
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 26'h00002AA; m0_dat_i = 16'h5A5A;
        tick(); #1;
        chk("t6_we", 32'(s_we_o), 1);
        chk("t6_wdat", 32'(s_dat_o), 32'h5A5A);
        tick();
        rst_n = 0; #1;
        chk("t6_rst_cyc", 32'(s_cyc_o), 0);
        chk("t6_rst_owner", 32'(owner_o), 0);
        chk("t6_rst_stall", 32'(m0_stall_o), 1);
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        tick();
        tick(); rst_n = 1; m1_cyc_i = 1; m1_stb_i = 1;
        tick(); #1;
        chk("t6_m1_grant", 32'(owner_o), 2);
        for (int i = 0; i < 3; i++) begin
            chk("t6_accept", 32'(m1_stall_o), 0);
            tick();
        end
        m1_stb_i = 0; s_ack_i = 1; #1;
        chk("t6_full", 32'(m1_stall_o), 1);
        tick();
        tick(); m1_cyc_i = 0;
        tick(); s_ack_i = 0; #1;
        chk("t6_idle", 32'(owner_o), 0);
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
